// File: rtl/if_id_fetch_queue_pkg.sv
// rtl/if_id_fetch_queue_pkg.sv - shared widths and sizing helpers for the IF/ID fetch queue
package if_id_fetch_queue_pkg;

   localparam int DEFAULT_BIT_NUMBER = 32;
   localparam int DEFAULT_DEPTH      = 4;

   // One entry carries the {pc, instruction} pair.
   function automatic int entry_width(input int bit_number);
      return 2 * bit_number;
   endfunction

   localparam int ENTRY_W = entry_width(DEFAULT_BIT_NUMBER);

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit so that count can represent DEPTH itself.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// rtl/if_id_fetch_queue_if.sv - fetch-side and decode-side signals of the IF/ID fetch queue
interface if_id_fetch_queue_if #(
   parameter int BIT_NUMBER = 32,
   parameter int DEPTH      = 4
);
   import if_id_fetch_queue_pkg::*;

   localparam int CW = count_width(DEPTH);

   logic                  flush;
   logic                  in_valid;
   logic [BIT_NUMBER-1:0] in_pc;
   logic [BIT_NUMBER-1:0] in_instruction;
   logic                  full;
   logic                  out_ready;
   logic                  out_valid;
   logic [BIT_NUMBER-1:0] out_pc;
   logic [BIT_NUMBER-1:0] out_instruction;
   logic [CW-1:0]         count;

   // master: the pipeline around the queue; slave: the queue itself
   modport master (
      output flush, in_valid, in_pc, in_instruction, out_ready,
      input  full, out_valid, out_pc, out_instruction, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_instruction, out_ready,
      output full, out_valid, out_pc, out_instruction, count
   );

endinterface

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - DEPTH-entry register array, synchronous write, asynchronous read, no reset
module fetch_queue_mem
   import if_id_fetch_queue_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [ptr_width(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic [ptr_width(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]            rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - in-order {pc, instruction} buffer between fetch and decode with flush
module if_id_fetch_queue
   import if_id_fetch_queue_pkg::*;
#(
   parameter int BIT_NUMBER = 32,
   parameter int DEPTH      = 4
) (
   input  logic               clk,
   input  logic               rst,
   if_id_fetch_queue_if.slave bus
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam int EW = entry_width(BIT_NUMBER);

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count_q;
   logic          full;
   logic          out_valid;
   logic          push;
   logic          pop;
   logic [EW-1:0] rd_data;

   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = (count_q != '0);

   // flush wins over both sides; a push is refused while full even if a pop frees a slot
   assign push = bus.in_valid & ~full & ~bus.flush;
   assign pop  = out_valid & bus.out_ready & ~bus.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   fetch_queue_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data ({bus.in_pc, bus.in_instruction}),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   // storage is never reset, so the head is masked while empty
   assign bus.out_pc          = out_valid ? rd_data[EW-1:BIT_NUMBER] : '0;
   assign bus.out_instruction = out_valid ? rd_data[BIT_NUMBER-1:0]  : '0;
   assign bus.out_valid       = out_valid;
   assign bus.full            = full;
   assign bus.count           = count_q;

   a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb/tb_if_id_fetch_queue.sv - directed table-driven bench for if_id_fetch_queue
module tb_if_id_fetch_queue;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   if_id_fetch_queue_if #(.BIT_NUMBER(32), .DEPTH(4)) bus ();

   if_id_fetch_queue #(.BIT_NUMBER(32), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        flush;
      logic        in_valid;
      logic [31:0] in_pc;
      logic        out_ready;
      logic        exp_valid;
      logic [31:0] exp_pc;
      int          exp_count;
      logic        exp_full;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] mq[$];

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hA5C3_0F00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input logic v, input logic [31:0] pc,
                              input int cnt, input logic f);
      check({name, ".valid"}, 32'(bus.out_valid), 32'(v));
      check({name, ".pc"}, bus.out_pc, pc);
      check({name, ".instr"}, bus.out_instruction, v ? instr_of(pc) : 32'h0);
      check({name, ".count"}, 32'(bus.count), 32'(cnt));
      check({name, ".full"}, 32'(bus.full), 32'(f));
   endtask

   task automatic apply(input logic fl, input logic iv, input logic [31:0] pc, input logic rdy);
      bus.flush          = fl;
      bus.in_valid       = iv;
      bus.in_pc          = pc;
      bus.in_instruction = instr_of(pc);
      bus.out_ready      = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] pc;
      logic        iv;
      logic        rdy;
      logic        push_m;
      logic        pop_m;
      total = 0;
      bad   = 0;

      // fill/refuse/drain, flush, and refused push while full with concurrent pop
      //                name     fl    iv    pc      rdy   v     exp_pc  cnt full
      vecs.push_back('{"fill1",  1'b0, 1'b1, 32'd4,  1'b0, 1'b1, 32'd4,   1, 1'b0});
      vecs.push_back('{"fill2",  1'b0, 1'b1, 32'd8,  1'b0, 1'b1, 32'd4,   2, 1'b0});
      vecs.push_back('{"fill3",  1'b0, 1'b1, 32'd12, 1'b0, 1'b1, 32'd4,   3, 1'b0});
      vecs.push_back('{"fill4",  1'b0, 1'b1, 32'd16, 1'b0, 1'b1, 32'd4,   4, 1'b1});
      vecs.push_back('{"refuse", 1'b0, 1'b1, 32'd20, 1'b0, 1'b1, 32'd4,   4, 1'b1});
      vecs.push_back('{"drain1", 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd8,   3, 1'b0});
      vecs.push_back('{"drain2", 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd12,  2, 1'b0});
      vecs.push_back('{"drain3", 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd16,  1, 1'b0});
      vecs.push_back('{"drain4", 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,   0, 1'b0});
      vecs.push_back('{"pre_f1", 1'b0, 1'b1, 32'd40, 1'b0, 1'b1, 32'd40,  1, 1'b0});
      vecs.push_back('{"pre_f2", 1'b0, 1'b1, 32'd44, 1'b0, 1'b1, 32'd40,  2, 1'b0});
      vecs.push_back('{"pre_f3", 1'b0, 1'b1, 32'd48, 1'b0, 1'b1, 32'd40,  3, 1'b0});
      vecs.push_back('{"flush",  1'b1, 1'b1, 32'd100,1'b1, 1'b0, 32'd0,   0, 1'b0});
      vecs.push_back('{"post_f", 1'b0, 1'b1, 32'd200,1'b0, 1'b1, 32'd200, 1, 1'b0});
      vecs.push_back('{"refil2", 1'b0, 1'b1, 32'd204,1'b0, 1'b1, 32'd200, 2, 1'b0});
      vecs.push_back('{"refil3", 1'b0, 1'b1, 32'd208,1'b0, 1'b1, 32'd200, 3, 1'b0});
      vecs.push_back('{"refil4", 1'b0, 1'b1, 32'd212,1'b0, 1'b1, 32'd200, 4, 1'b1});
      vecs.push_back('{"fullpp", 1'b0, 1'b1, 32'd216,1'b1, 1'b1, 32'd204, 3, 1'b0});
      vecs.push_back('{"flush2", 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,   0, 1'b0});

      rst = 1'b1;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0;
      bus.in_instruction = '0; bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      check_state("reset", 1'b0, 32'd0, 0, 1'b0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         apply(vecs[i].flush, vecs[i].in_valid, vecs[i].in_pc, vecs[i].out_ready);
         check_state(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_pc,
                     vecs[i].exp_count, vecs[i].exp_full);
      end

      // pass-through: each pc at the head one edge after entry, count pinned at 1
      pc = 32'd4;
      for (int k = 0; k < 6; k++) begin
         apply(1'b0, 1'b1, pc, 1'b1);
         check_state("pass", 1'b1, pc, 1, 1'b0);
         pc += 32'd4;
      end
      apply(1'b0, 1'b0, 32'd0, 1'b1);
      check_state("pass_end", 1'b0, 32'd0, 0, 1'b0);

      // wrap-around against a queue model
      pc = 32'h1000;
      for (int k = 0; k < 10; k++) begin
         iv     = (k % 3) != 2;
         rdy    = (k >= 4) && (k % 2 == 0);
         push_m = iv && (mq.size() < 4);
         pop_m  = rdy && (mq.size() > 0);
         apply(1'b0, iv, pc, rdy);
         if (pop_m) void'(mq.pop_front());
         if (push_m) begin
            mq.push_back(pc);
            pc += 32'd4;
         end
         check_state("wrap", 1'b1, mq[0], mq.size(), mq.size() == 4);
         check("wrap_cnt_le4", 32'(bus.count <= 3'd4), 32'd1);
      end
      for (int k = 0; k < 8 && mq.size() > 0; k++) begin
         apply(1'b0, 1'b0, 32'd0, 1'b1);
         void'(mq.pop_front());
         if (mq.size() > 0) check_state("wrap_drain", 1'b1, mq[0], mq.size(), 1'b0);
         else               check_state("wrap_drain", 1'b0, 32'd0, 0, 1'b0);
      end

      // asynchronous reset in the middle of a cycle
      apply(1'b0, 1'b1, 32'd300, 1'b0);
      apply(1'b0, 1'b1, 32'd304, 1'b0);
      check_state("pre_rst", 1'b1, 32'd300, 2, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_state("async_rst", 1'b0, 32'd0, 0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply(1'b0, 1'b1, 32'd400, 1'b0);
      check_state("after_rst", 1'b1, 32'd400, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
